// File: rtl/video_mono_pipe_if.sv
// video_mono_pipe_if
//   Bundles one video stream: colour components plus sync and display enable.
//   W is the per-component colour width (6 on the system side, 8 on the
//   VGA side).
//   master : drives r, g, b, hs, vs, de
//   slave  : receives r, g, b, hs, vs, de
interface video_mono_pipe_if #(
  parameter int W = 6
);
  logic [W-1:0] r;
  logic [W-1:0] g;
  logic [W-1:0] b;
  logic         hs;
  logic         vs;
  logic         de;

  modport master (output r, g, b, hs, vs, de);
  modport slave  (input  r, g, b, hs, vs, de);
endinterface

// File: rtl/video_mono_pipe.sv
// video_mono_pipe
//   Two-stage registered colour-to-monitor conversion between the system
//   video outputs and the VGA pins. Emulates colour, green, amber and B/W
//   monitors from Rec.709 luma. Syncs and DE travel with the pixel data, so
//   every output lags its input by exactly two clk_vga cycles.
//   Ports:
//     clk_vga  : pixel clock
//     reset_n  : synchronous active-low reset
//     mode_i   : requested monitor mode (0 colour, 1 green, 2 amber, 3 B/W)
//     mode_o   : mode currently applied to incoming pixels
//     vid_in   : 6-bit system video (r, g, b, hs, vs, de)
//     vid_out  : 8-bit VGA video (r, g, b, hs, vs, de)
module video_mono_pipe #(
  parameter bit VS_POL           = 1'b0,
  parameter bit SYNC_MODE_CHANGE = 1'b1
) (
  input  logic              clk_vga,
  input  logic              reset_n,
  input  logic [1:0]        mode_i,
  output logic [1:0]        mode_o,
  video_mono_pipe_if.slave  vid_in,
  video_mono_pipe_if.master vid_out
);

  localparam bit VS_IDLE = ~VS_POL;

  typedef enum logic [1:0] {
    MODE_COLOUR = 2'd0,
    MODE_GREEN  = 2'd1,
    MODE_AMBER  = 2'd2,
    MODE_BW     = 2'd3
  } mode_t;

  logic [1:0]  mode_active;
  logic        vs_prev;
  logic        vsync_start;

  logic [5:0]  r_s1, g_s1, b_s1;
  logic        hs_s1, vs_s1, de_s1;
  logic [13:0] sum_s1;
  logic [1:0]  mode_s1;
  logic [13:0] sum_next;

  logic [7:0]  luma_full;
  logic [5:0]  luma;
  logic [5:0]  r_pix, g_pix, b_pix;

  // Replicating the top bits makes full-scale 63 map to 0xFF and 0 to 0x00.
  function automatic logic [7:0] expand6(input logic [5:0] x);
    return {x, x[5:4]};
  endfunction

  // Leading edge of VSync: the only point where a new mode may be adopted,
  // so a frame is never rendered in two modes.
  assign vsync_start = (vid_in.vs == VS_POL) && (vs_prev != VS_POL);

  // vs_prev resets to the idle level so a VSync already active out of reset
  // is not mistaken for a new frame.
  always_ff @(posedge clk_vga) begin
    if (!reset_n) begin
      mode_active <= MODE_COLOUR;
      vs_prev     <= VS_IDLE;
    end else begin
      vs_prev <= vid_in.vs;
      if (!SYNC_MODE_CHANGE || vsync_start) begin
        mode_active <= mode_i;
      end
    end
  end

  assign mode_o = mode_active;

  // 14 bits hold the worst case 255*63 + 128 = 16193.
  assign sum_next = 14'd54  * {8'd0, vid_in.r}
                  + 14'd183 * {8'd0, vid_in.g}
                  + 14'd18  * {8'd0, vid_in.b}
                  + 14'd128;

  always_ff @(posedge clk_vga) begin
    if (!reset_n) begin
      r_s1    <= '0;
      g_s1    <= '0;
      b_s1    <= '0;
      hs_s1   <= 1'b0;
      vs_s1   <= VS_IDLE;
      de_s1   <= 1'b0;
      sum_s1  <= '0;
      mode_s1 <= MODE_COLOUR;
    end else begin
      r_s1    <= vid_in.r;
      g_s1    <= vid_in.g;
      b_s1    <= vid_in.b;
      hs_s1   <= vid_in.hs;
      vs_s1   <= vid_in.vs;
      de_s1   <= vid_in.de;
      sum_s1  <= sum_next;
      mode_s1 <= mode_active;
    end
  end

  // The clamp keeps luma in range should the coefficients ever be retuned;
  // with the current weights the top six bits cannot exceed 63.
  always_comb begin
    luma_full = {2'b00, sum_s1[13:8]};
    luma      = (luma_full > 8'd63) ? 6'd63 : luma_full[5:0];
    r_pix     = '0;
    g_pix     = '0;
    b_pix     = '0;
    if (de_s1) begin
      case (mode_t'(mode_s1))
        MODE_COLOUR: begin
          r_pix = r_s1;
          g_pix = g_s1;
          b_pix = b_s1;
        end
        MODE_GREEN: begin
          g_pix = luma;
        end
        MODE_AMBER: begin
          r_pix = luma;
          g_pix = {1'b0, luma[5:1]};
        end
        MODE_BW: begin
          r_pix = luma;
          g_pix = luma;
          b_pix = luma;
        end
        default: begin
          r_pix = r_s1;
          g_pix = g_s1;
          b_pix = b_s1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_vga) begin
    if (!reset_n) begin
      vid_out.r  <= '0;
      vid_out.g  <= '0;
      vid_out.b  <= '0;
      vid_out.hs <= 1'b0;
      vid_out.vs <= VS_IDLE;
      vid_out.de <= 1'b0;
    end else begin
      vid_out.r  <= expand6(r_pix);
      vid_out.g  <= expand6(g_pix);
      vid_out.b  <= expand6(b_pix);
      vid_out.hs <= hs_s1;
      vid_out.vs <= vs_s1;
      vid_out.de <= de_s1;
    end
  end

endmodule
